// File: rtl/router_pkg.sv
// Shared helpers for the parametrised ring router: VC id width derivation,
// destination field extraction and default flit/node-id widths.
package router_pkg;

  localparam int DEF_FLIT_W = 8;
  localparam int DEF_NODE_W = 2;

  // VC id width: max(1, clog2(num_vc)) so a single-VC router still has a 1-bit tag
  function automatic int vc_width(input int num_vc);
    return (num_vc <= 2) ? 1 : $clog2(num_vc);
  endfunction

  // Destination lives in the top node_w bits of the flit
  function automatic logic [31:0] dest_of(input logic [63:0] flit, input int flit_w,
                                          input int node_w);
    return 32'((flit >> (flit_w - node_w)) & ((64'd1 << node_w) - 64'd1));
  endfunction

endpackage

// File: rtl/vc_fifo.sv
// Per-VC input FIFO. Pointers carry one extra wrap bit so full and empty are
// distinguished without a counter. The head is read combinationally so a flit
// written at one edge can be arbitrated in the very next cycle.
module vc_fifo
  import router_pkg::*;
#(
  parameter int W     = DEF_FLIT_W,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr_reg;
  logic [AW:0]  rd_ptr_reg;

  assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                 (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign empty = (wr_ptr_reg == rd_ptr_reg);
  assign head  = mem[rd_ptr_reg[AW-1:0]];

  // Pointer advance; a push into a full FIFO is refused even if it pops this cycle
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (push && !full) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop && !empty) rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end

  // Storage write (no reset on the array so it can map to RAM)
  always_ff @(posedge clk) begin
    if (push && !full) mem[wr_ptr_reg[AW-1:0]] <= din;
  end

endmodule

// File: rtl/router_vc_param.sv
// Single-input ring router node: NUM_VC input FIFOs plus an NI injection port
// feed two round-robin arbiters (downstream and local eject), each driving a
// registered valid/ready output. Define ROUTER_STATS_EN to add saturating
// forward/eject handshake counters.
module router_vc_param
  import router_pkg::*;
#(
  parameter int FLIT_W   = DEF_FLIT_W,
  parameter int NUM_VC   = 2,
  parameter int VC_DEPTH = 4,
  parameter int NODE_W   = DEF_NODE_W,
  parameter int NODE_ID  = 0,
  parameter int NI_VC    = 0,
  localparam int VC_W    = vc_width(NUM_VC)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [FLIT_W-1:0] in_flit,
  input  logic [VC_W-1:0]   in_vc,
  input  logic              in_valid,
  output logic [NUM_VC-1:0] in_ready,
  input  logic [FLIT_W-1:0] ni_flit,
  input  logic              ni_valid,
  output logic              ni_ready,
  output logic [FLIT_W-1:0] down_flit,
  output logic [VC_W-1:0]   down_vc,
  output logic              down_valid,
  input  logic              down_ready,
  output logic [FLIT_W-1:0] eject_flit,
  output logic              eject_valid,
  input  logic              eject_ready
`ifdef ROUTER_STATS_EN
  ,
  output logic [15:0]       fwd_count,
  output logic [15:0]       eject_count
`endif
);

  // Requesters 0..NUM_VC-1 are VC heads, requester NUM_VC is the NI
  localparam int NREQ  = NUM_VC + 1;
  localparam int PTR_W = $clog2(NREQ);

  logic [NUM_VC-1:0] push, pop, full, empty;
  logic [FLIT_W-1:0] head     [NUM_VC];
  logic [FLIT_W-1:0] req_flit [NREQ];
  logic [VC_W-1:0]   req_vc   [NREQ];
  logic [NREQ-1:0]   req_down, req_eject;

  logic              down_valid_reg, eject_valid_reg;
  logic [FLIT_W-1:0] down_flit_reg, eject_flit_reg;
  logic [VC_W-1:0]   down_vc_reg;
  logic [PTR_W-1:0]  down_ptr_reg, eject_ptr_reg;

  logic              down_load, down_hit, down_gnt;
  logic              eject_load, eject_hit, eject_gnt;
  logic [PTR_W-1:0]  down_win, eject_win;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_VC; gi++) begin : g_vc
      // Out-of-range in_vc values simply match no FIFO and are dropped
      assign push[gi] = in_valid && (in_vc == VC_W'(gi)) && !full[gi];
      assign pop[gi]  = (down_gnt && (down_win == PTR_W'(gi))) ||
                        (eject_gnt && (eject_win == PTR_W'(gi)));

      vc_fifo #(.W(FLIT_W), .DEPTH(VC_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push[gi]),
        .pop   (pop[gi]),
        .din   (in_flit),
        .full  (full[gi]),
        .empty (empty[gi]),
        .head  (head[gi])
      );

      assign req_flit[gi]  = head[gi];
      assign req_vc[gi]    = VC_W'(gi);
      assign req_eject[gi] = !empty[gi] &&
                             (dest_of(64'(head[gi]), FLIT_W, NODE_W) == 32'(NODE_ID));
      assign req_down[gi]  = !empty[gi] &&
                             (dest_of(64'(head[gi]), FLIT_W, NODE_W) != 32'(NODE_ID));
    end
  endgenerate

  assign req_flit[NUM_VC]  = ni_flit;
  assign req_vc[NUM_VC]    = VC_W'(NI_VC);
  assign req_eject[NUM_VC] = ni_valid &&
                             (dest_of(64'(ni_flit), FLIT_W, NODE_W) == 32'(NODE_ID));
  assign req_down[NUM_VC]  = ni_valid &&
                             (dest_of(64'(ni_flit), FLIT_W, NODE_W) != 32'(NODE_ID));

  assign in_ready    = ~full;
  assign ni_ready    = (down_gnt && (down_win == PTR_W'(NUM_VC))) ||
                       (eject_gnt && (eject_win == PTR_W'(NUM_VC)));
  assign down_flit   = down_flit_reg;
  assign down_vc     = down_vc_reg;
  assign down_valid  = down_valid_reg;
  assign eject_flit  = eject_flit_reg;
  assign eject_valid = eject_valid_reg;

  // First requester at or after ptr, cyclically; scanning far-to-near lets the nearest win
  function automatic void rr_pick(input logic [NREQ-1:0] req, input logic [PTR_W-1:0] ptr,
                                  output logic hit, output logic [PTR_W-1:0] win);
    int idx;
    hit = 1'b0;
    win = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (req[idx]) begin
        hit = 1'b1;
        win = PTR_W'(idx);
      end
    end
  endfunction

  function automatic logic [PTR_W-1:0] ptr_after(input logic [PTR_W-1:0] win);
    return (int'(win) == NREQ - 1) ? '0 : win + 1'b1;
  endfunction

  // Arbitration: each arbiter grants only when its output register can load
  always_comb begin
    down_hit   = 1'b0;
    down_win   = '0;
    eject_hit  = 1'b0;
    eject_win  = '0;
    down_load  = !down_valid_reg || down_ready;
    eject_load = !eject_valid_reg || eject_ready;
    rr_pick(req_down, down_ptr_reg, down_hit, down_win);
    rr_pick(req_eject, eject_ptr_reg, eject_hit, eject_win);
    down_gnt   = down_load && down_hit;
    eject_gnt  = eject_load && eject_hit;
  end

  // Downstream output register and its round-robin pointer
  always_ff @(posedge clk) begin
    if (!rst) begin
      down_valid_reg <= 1'b0;
      down_flit_reg  <= '0;
      down_vc_reg    <= '0;
      down_ptr_reg   <= '0;
    end else if (down_load) begin
      down_valid_reg <= down_gnt;
      if (down_gnt) begin
        down_flit_reg <= req_flit[down_win];
        down_vc_reg   <= req_vc[down_win];
        down_ptr_reg  <= ptr_after(down_win);
      end
    end
  end

  // Eject output register and its round-robin pointer
  always_ff @(posedge clk) begin
    if (!rst) begin
      eject_valid_reg <= 1'b0;
      eject_flit_reg  <= '0;
      eject_ptr_reg   <= '0;
    end else if (eject_load) begin
      eject_valid_reg <= eject_gnt;
      if (eject_gnt) begin
        eject_flit_reg <= req_flit[eject_win];
        eject_ptr_reg  <= ptr_after(eject_win);
      end
    end
  end

`ifdef ROUTER_STATS_EN
  logic [15:0] fwd_count_reg, eject_count_reg;
  assign fwd_count   = fwd_count_reg;
  assign eject_count = eject_count_reg;

  // Saturating handshake counters
  always_ff @(posedge clk) begin
    if (!rst) begin
      fwd_count_reg   <= '0;
      eject_count_reg <= '0;
    end else begin
      if (down_valid_reg && down_ready && fwd_count_reg != 16'hFFFF)
        fwd_count_reg <= fwd_count_reg + 16'd1;
      if (eject_valid_reg && eject_ready && eject_count_reg != 16'hFFFF)
        eject_count_reg <= eject_count_reg + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_router_vc_param.sv
// Bench for router_vc_param: queue-based reference model stepped once per
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_router_vc_param;

  localparam int NUM_VC  = 2;
  localparam int DEPTH   = 4;
  localparam int NODE_ID = 0;
  localparam int NI_VC   = 1;
  localparam int NREQ    = NUM_VC + 1;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_flit;
  logic [0:0] in_vc;
  logic       in_valid;
  logic [1:0] in_ready;
  logic [7:0] ni_flit;
  logic       ni_valid;
  logic       ni_ready;
  logic [7:0] down_flit;
  logic [0:0] down_vc;
  logic       down_valid;
  logic       down_ready;
  logic [7:0] eject_flit;
  logic       eject_valid;
  logic       eject_ready;
`ifdef ROUTER_STATS_EN
  logic [15:0] fwd_count, eject_count;
  int          m_fwd = 0, m_ej = 0;
`endif

  always #5 clk = ~clk;

  router_vc_param #(
    .FLIT_W(8), .NUM_VC(NUM_VC), .VC_DEPTH(DEPTH), .NODE_W(2),
    .NODE_ID(NODE_ID), .NI_VC(NI_VC)
  ) dut (
    .clk(clk), .rst(rst),
    .in_flit(in_flit), .in_vc(in_vc), .in_valid(in_valid), .in_ready(in_ready),
    .ni_flit(ni_flit), .ni_valid(ni_valid), .ni_ready(ni_ready),
    .down_flit(down_flit), .down_vc(down_vc), .down_valid(down_valid),
    .down_ready(down_ready),
    .eject_flit(eject_flit), .eject_valid(eject_valid), .eject_ready(eject_ready)
`ifdef ROUTER_STATS_EN
    , .fwd_count(fwd_count), .eject_count(eject_count)
`endif
  );

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [7:0] mq [NUM_VC][$];
  bit         m_dv = 0, m_ev = 0;
  logic [7:0] m_df = 0, m_ef = 0;
  int         m_dvc = 0;
  int         m_dptr = 0, m_eptr = 0;
  logic [7:0] down_log[$];
  int         vc_log[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int dest(input logic [7:0] f);
    return int'(f[7:6]);
  endfunction

  // Winner = requester with the smallest cyclic distance from ptr, -1 if none
  function automatic int rr(input bit req [NREQ], input int ptr);
    int best  = -1;
    int bestd = NREQ;
    for (int i = 0; i < NREQ; i++) begin
      if (req[i] && ((i - ptr + NREQ) % NREQ) < bestd) begin
        bestd = (i - ptr + NREQ) % NREQ;
        best  = i;
      end
    end
    return best;
  endfunction

  // One clock: drive at negedge, check combinational outputs, step model,
  // then check registered outputs at the following negedge.
  task automatic cycle(input bit r_n, input bit iv, input int ivc, input logic [7:0] ifl,
                       input bit nv, input logic [7:0] nfl, input bit dr, input bit er);
    bit         rd [NREQ];
    bit         re [NREQ];
    int         wd, we;
    bit         do_push;
    logic [1:0] exp_rdy;
    rst = r_n; in_valid = iv; in_vc = ivc[0]; in_flit = ifl;
    ni_valid = nv; ni_flit = nfl; down_ready = dr; eject_ready = er;
    #1;
    for (int v = 0; v < NUM_VC; v++) begin
      exp_rdy[v] = (mq[v].size() < DEPTH);
      rd[v] = (mq[v].size() > 0) && (dest(mq[v][0]) != NODE_ID);
      re[v] = (mq[v].size() > 0) && (dest(mq[v][0]) == NODE_ID);
    end
    rd[NUM_VC] = nv && (dest(nfl) != NODE_ID);
    re[NUM_VC] = nv && (dest(nfl) == NODE_ID);
    wd = (!m_dv || dr) ? rr(rd, m_dptr) : -1;
    we = (!m_ev || er) ? rr(re, m_eptr) : -1;
    chk("in_ready", in_ready, exp_rdy);
    if (r_n) chk("ni_ready", ni_ready, (wd == NUM_VC) || (we == NUM_VC));
    if (down_valid && dr) begin
      down_log.push_back(down_flit);
      vc_log.push_back(int'(down_vc));
    end
    if (!r_n) begin
      for (int v = 0; v < NUM_VC; v++) mq[v].delete();
      m_dv = 0; m_ev = 0; m_df = 0; m_ef = 0; m_dvc = 0; m_dptr = 0; m_eptr = 0;
`ifdef ROUTER_STATS_EN
      m_fwd = 0; m_ej = 0;
`endif
    end else begin
`ifdef ROUTER_STATS_EN
      if (m_dv && dr && m_fwd < 65535) m_fwd++;
      if (m_ev && er && m_ej < 65535) m_ej++;
`endif
      do_push = iv && (ivc < NUM_VC) && (mq[ivc].size() < DEPTH);
      if (!m_dv || dr) begin
        m_dv = (wd >= 0);
        if (wd >= 0) begin
          if (wd < NUM_VC) begin m_df = mq[wd].pop_front(); m_dvc = wd; end
          else begin m_df = nfl; m_dvc = NI_VC; end
          m_dptr = (wd + 1) % NREQ;
        end
      end
      if (!m_ev || er) begin
        m_ev = (we >= 0);
        if (we >= 0) begin
          if (we < NUM_VC) m_ef = mq[we].pop_front();
          else m_ef = nfl;
          m_eptr = (we + 1) % NREQ;
        end
      end
      if (do_push) mq[ivc].push_back(ifl);
    end
    @(posedge clk);
    @(negedge clk);
    chk("down_valid", down_valid, m_dv);
    chk("eject_valid", eject_valid, m_ev);
    if (m_dv) begin
      chk("down_flit", down_flit, m_df);
      chk("down_vc", down_vc, m_dvc);
    end
    if (m_ev) chk("eject_flit", eject_flit, m_ef);
`ifdef ROUTER_STATS_EN
    chk("fwd_count", fwd_count, m_fwd);
    chk("eject_count", eject_count, m_ej);
`endif
  endtask

  task automatic idle(input bit dr, input bit er);
    cycle(1'b1, 1'b0, 0, 8'h00, 1'b0, 8'h00, dr, er);
  endtask

  initial begin
    rst = 1'b0; in_valid = 1'b0; in_vc = '0; in_flit = '0;
    ni_valid = 1'b0; ni_flit = '0; down_ready = 1'b1; eject_ready = 1'b1;
    @(negedge clk);
    cycle(1'b0, 1'b0, 0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1);
    cycle(1'b0, 1'b0, 0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1);
    idle(1'b1, 1'b1);
    chk("rst_in_ready", in_ready, 2'b11);
    chk("rst_down_valid", down_valid, 1'b0);
    chk("rst_eject_valid", eject_valid, 1'b0);
    chk("rst_ni_ready", ni_ready, 1'b0);

    // Forward and eject latency
    cycle(1'b1, 1'b1, 0, 8'h45, 1'b0, 8'h00, 1'b1, 1'b1);
    chk("lat_not_yet", down_valid, 1'b0);
    idle(1'b1, 1'b1);
    chk("fwd_valid", down_valid, 1'b1);
    chk("fwd_flit", down_flit, 8'h45);
    chk("fwd_vc", down_vc, 1'b0);
    cycle(1'b1, 1'b1, 0, 8'h05, 1'b0, 8'h00, 1'b1, 1'b1);
    idle(1'b1, 1'b1);
    chk("ej_valid", eject_valid, 1'b1);
    chk("ej_flit", eject_flit, 8'h05);
    repeat (3) idle(1'b1, 1'b1);

    // Back-pressure fill of vc1: output register absorbs one flit, FIFO the next four
    for (int i = 0; i < 6; i++) begin
      cycle(1'b1, 1'b1, 1, 8'h41 + 8'(i), 1'b0, 8'h00, 1'b0, 1'b1);
      if (i == 4) chk("full_in_ready", in_ready, 2'b01);
    end
    down_log.delete(); vc_log.delete();
    repeat (8) idle(1'b1, 1'b1);
    chk("drain_count", down_log.size(), 5);
    for (int i = 0; i < 5 && i < down_log.size(); i++)
      chk("drain_order", down_log[i], 8'h41 + 8'(i));
    chk("drain_in_ready", in_ready, 2'b11);

    // Round-robin rotation vc0, vc1, NI
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, 0, 8'h50 + 8'(i), 1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, 1, 8'h60 + 8'(i), 1'b0, 8'h00, 1'b0, 1'b1);
    down_log.delete(); vc_log.delete();
    repeat (6) cycle(1'b1, 1'b0, 0, 8'h00, 1'b1, 8'h77, 1'b1, 1'b1);
    begin
      logic [7:0] exp_f [6];
      int         exp_v [6];
      exp_f = '{8'h50, 8'h60, 8'h77, 8'h51, 8'h61, 8'h77};
      exp_v = '{0, 1, NI_VC, 0, 1, NI_VC};
      chk("rr_count", down_log.size(), 6);
      for (int i = 0; i < 6 && i < down_log.size(); i++) begin
        chk("rr_flit", down_log[i], exp_f[i]);
        chk("rr_vc", vc_log[i], exp_v[i]);
      end
    end
    repeat (10) idle(1'b1, 1'b1);

    // Eject and forward valid in the same cycle
    cycle(1'b1, 1'b1, 0, 8'h0A, 1'b0, 8'h00, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1, 8'h8B, 1'b0, 8'h00, 1'b0, 1'b0);
    idle(1'b0, 1'b0);
    chk("both_ej_valid", eject_valid, 1'b1);
    chk("both_dn_valid", down_valid, 1'b1);
    chk("both_ej_flit", eject_flit, 8'h0A);
    chk("both_dn_flit", down_flit, 8'h8B);
    repeat (4) idle(1'b1, 1'b1);

    // Reset with traffic in flight
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 0, 8'h40 + 8'(i), 1'b0, 8'h00, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1, 8'h01, 1'b0, 8'h00, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1, 8'h02, 1'b0, 8'h00, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 0, 8'h55, 1'b1, 8'h66, 1'b1, 1'b1);
    chk("mid_rst_down_valid", down_valid, 1'b0);
    chk("mid_rst_eject_valid", eject_valid, 1'b0);
    chk("mid_rst_in_ready", in_ready, 2'b11);
    chk("mid_rst_down_flit", down_flit, 8'h00);
    chk("mid_rst_eject_flit", eject_flit, 8'h00);
    chk("mid_rst_down_vc", down_vc, 1'b0);
`ifdef ROUTER_STATS_EN
    chk("mid_rst_fwd_count", fwd_count, 16'd0);
    chk("mid_rst_eject_count", eject_count, 16'd0);
`endif
    idle(1'b1, 1'b1);
    chk("post_rst_down_valid", down_valid, 1'b0);

    // Random traffic against the model
    for (int n = 0; n < 3000; n++) begin
      cycle($urandom_range(0, 299) != 0, 1'($urandom_range(0, 1)), int'($urandom_range(0, 1)),
            8'($urandom), 1'($urandom_range(0, 2) == 0), 8'($urandom),
            $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
